// File: rtl/axis_pkt_switch.sv
// NxM packet-atomic AXI-Stream switch routed by dst SID through a 512-entry table.
// Define AXIS_PKT_SWITCH_STATS_EN to build per-port and drop packet counters.
module axis_pkt_switch #(
  parameter int unsigned BASE        = 0,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned OUT_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [7:0]                    local_addr,
  input  logic [NUM_INPUTS*DATA_W-1:0]  s_tdata,
  input  logic [NUM_INPUTS-1:0]         s_tvalid,
  input  logic [NUM_INPUTS-1:0]         s_tlast,
  output logic [NUM_INPUTS-1:0]         s_tready,
  output logic [NUM_OUTPUTS*DATA_W-1:0] m_tdata,
  output logic [NUM_OUTPUTS-1:0]        m_tvalid,
  output logic [NUM_OUTPUTS-1:0]        m_tlast,
  input  logic [NUM_OUTPUTS-1:0]        m_tready,
  input  logic                          set_stb,
  input  logic [15:0]                   set_addr,
  input  logic [31:0]                   set_data,
  input  logic                          rb_rd_stb,
  input  logic [9:0]                    rb_addr,
  output logic [31:0]                   rb_data
);

  localparam int unsigned IN_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned TBL_N = 512;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REQ, S_FWD, S_DROP} state_t;

  logic             tbl_vld_q  [TBL_N];
  logic [OUT_W-1:0] tbl_port_q [TBL_N];
  logic [31:0]      wr_off;
  logic             wr_en;
  logic             wr_vld;
  logic             unused_set_bits;

  state_t           st_q   [NUM_INPUTS];
  state_t           st_d   [NUM_INPUTS];
  logic [15:0]      dst_q  [NUM_INPUTS];
  logic [15:0]      dst_d  [NUM_INPUTS];
  logic [OUT_W-1:0] port_q [NUM_INPUTS];
  logic [OUT_W-1:0] port_d [NUM_INPUTS];
  logic [8:0]       lk_idx [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] s_last_hs;

  logic            gnt_vld_q  [NUM_OUTPUTS];
  logic            gnt_vld_d  [NUM_OUTPUTS];
  logic [IN_W-1:0] gnt_idx_q  [NUM_OUTPUTS];
  logic [IN_W-1:0] gnt_idx_d  [NUM_OUTPUTS];
  logic [IN_W-1:0] last_q     [NUM_OUTPUTS];
  logic [IN_W-1:0] last_d     [NUM_OUTPUTS];
  logic [NUM_INPUTS-1:0] req     [NUM_OUTPUTS];
  logic [NUM_INPUTS-1:0] new_gnt [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] rel;
  logic            found;

  logic [31:0] rb_d;
  logic [31:0] rb_data_q;
  logic [31:0] cnt_rd;

  // Route table; ports that do not exist are stored as invalid
  always_comb begin
    wr_off = 32'(set_addr) - BASE;
    wr_en  = set_stb && (32'(set_addr) >= BASE) && (wr_off < TBL_N);
    wr_vld = set_data[31] && (32'(set_data[OUT_W-1:0]) < NUM_OUTPUTS);
  end

  assign unused_set_bits = ^set_data[30:OUT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned e = 0; e < TBL_N; e++) begin
        tbl_vld_q[e]  <= 1'b0;
        tbl_port_q[e] <= '0;
      end
    end else if (wr_en) begin
      tbl_vld_q[wr_off[8:0]]  <= wr_vld;
      tbl_port_q[wr_off[8:0]] <= set_data[OUT_W-1:0];
    end
  end

  // Output muxes driven by the held grants
  always_comb begin
    m_tdata  = '0;
    m_tvalid = '0;
    m_tlast  = '0;
    for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (gnt_vld_q[j] && gnt_idx_q[j] == IN_W'(i)) begin
          m_tdata[j*DATA_W +: DATA_W] = s_tdata[i*DATA_W +: DATA_W];
          m_tvalid[j] = s_tvalid[i];
          m_tlast[j]  = s_tlast[i];
        end
      end
    end
    rel = m_tvalid & m_tready & m_tlast;
  end

  always_comb begin
    s_tready = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      case (st_q[i])
        S_FWD: begin
          for (int unsigned j = 0; j < NUM_OUTPUTS; j++)
            if (port_q[i] == OUT_W'(j)) s_tready[i] = m_tready[j];
        end
        S_DROP:  s_tready[i] = 1'b1;
        default: s_tready[i] = 1'b0;
      endcase
    end
    s_last_hs = s_tvalid & s_tready & s_tlast;
  end

  // Round-robin: a freed output (idle or releasing this cycle) picks the first
  // requester after last_q, so a new grant registers on the tlast beat.
  always_comb begin
    found = 1'b0;
    for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
      gnt_vld_d[j] = gnt_vld_q[j];
      gnt_idx_d[j] = gnt_idx_q[j];
      last_d[j]    = last_q[j];
      new_gnt[j]   = '0;
      req[j]       = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++)
        req[j][i] = (st_q[i] == S_REQ) && (port_q[i] == OUT_W'(j));
      if (!gnt_vld_q[j] || rel[j]) begin
        gnt_vld_d[j] = 1'b0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
          for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (!found && req[j][i] && i == (32'(last_q[j]) + k) % NUM_INPUTS) begin
              found         = 1'b1;
              gnt_vld_d[j]  = 1'b1;
              gnt_idx_d[j]  = IN_W'(i);
              last_d[j]     = IN_W'(i);
              new_gnt[j][i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      st_d[i]   = st_q[i];
      dst_d[i]  = dst_q[i];
      port_d[i] = port_q[i];
      lk_idx[i] = (dst_q[i][15:8] == local_addr) ? {1'b1, dst_q[i][7:0]}
                                                 : {1'b0, dst_q[i][15:8]};
      case (st_q[i])
        S_IDLE: begin
          if (s_tvalid[i]) begin
            dst_d[i] = s_tdata[i*DATA_W +: 16];
            st_d[i]  = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          port_d[i] = tbl_port_q[lk_idx[i]];
          st_d[i]   = tbl_vld_q[lk_idx[i]] ? S_REQ : S_DROP;
        end
        S_REQ: begin
          for (int unsigned j = 0; j < NUM_OUTPUTS; j++)
            if (port_q[i] == OUT_W'(j) && new_gnt[j][i]) st_d[i] = S_FWD;
        end
        S_FWD, S_DROP: begin
          if (s_last_hs[i]) st_d[i] = S_IDLE;
        end
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        st_q[i]   <= S_IDLE;
        dst_q[i]  <= '0;
        port_q[i] <= '0;
      end
      for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
        gnt_vld_q[j] <= 1'b0;
        gnt_idx_q[j] <= '0;
        last_q[j]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        st_q[i]   <= st_d[i];
        dst_q[i]  <= dst_d[i];
        port_q[i] <= port_d[i];
      end
      for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
        gnt_vld_q[j] <= gnt_vld_d[j];
        gnt_idx_q[j] <= gnt_idx_d[j];
        last_q[j]    <= last_d[j];
      end
    end
  end

`ifdef AXIS_PKT_SWITCH_STATS_EN
  logic [31:0] in_cnt_q  [NUM_INPUTS];
  logic [31:0] out_cnt_q [NUM_OUTPUTS];
  logic [31:0] drop_cnt_q;
  logic [31:0] drop_inc;

  always_comb begin
    drop_inc = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++)
      if (st_q[i] == S_DROP && s_last_hs[i]) drop_inc = drop_inc + 32'd1;
    cnt_rd = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++)
      if (rb_addr[8:0] == 9'(i)) cnt_rd = in_cnt_q[i];
    for (int unsigned j = 0; j < NUM_OUTPUTS; j++)
      if (rb_addr[8:0] == 9'(NUM_INPUTS + j)) cnt_rd = out_cnt_q[j];
    if (rb_addr[8:0] == 9'(NUM_INPUTS + NUM_OUTPUTS)) cnt_rd = drop_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) in_cnt_q[i] <= '0;
      for (int unsigned j = 0; j < NUM_OUTPUTS; j++) out_cnt_q[j] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++)
        if (s_last_hs[i]) in_cnt_q[i] <= in_cnt_q[i] + 32'd1;
      for (int unsigned j = 0; j < NUM_OUTPUTS; j++)
        if (rel[j]) out_cnt_q[j] <= out_cnt_q[j] + 32'd1;
      drop_cnt_q <= drop_cnt_q + drop_inc;
    end
  end
`else
  assign cnt_rd = '0;
`endif

  always_comb begin
    rb_d = '0;
    if (!rb_addr[9]) begin
      rb_d[31]        = tbl_vld_q[rb_addr[8:0]];
      rb_d[OUT_W-1:0] = tbl_port_q[rb_addr[8:0]];
    end else begin
      rb_d = cnt_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rb_data_q <= '0;
    else if (rb_rd_stb) rb_data_q <= rb_d;
  end

  assign rb_data = rb_data_q;

endmodule

// File: tb/tb_axis_pkt_switch.sv
// Scoreboard bench for axis_pkt_switch: directed packets, per-output expected-beat queues.
module tb_axis_pkt_switch;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, clear;
  logic [7:0]        local_addr;
  logic [NI*DW-1:0]  s_tdata;
  logic [NI-1:0]     s_tvalid, s_tlast, s_tready;
  logic [NO*DW-1:0]  m_tdata;
  logic [NO-1:0]     m_tvalid, m_tlast, m_tready;
  logic              set_stb;
  logic [15:0]       set_addr;
  logic [31:0]       set_data;
  logic              rb_rd_stb;
  logic [9:0]        rb_addr;
  logic [31:0]       rb_data;

  logic          tv [NI];
  logic          tl [NI];
  logic [DW-1:0] td [NI];
  logic          mr [NO];

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      s_tvalid[i]        = tv[i];
      s_tlast[i]         = tl[i];
      s_tdata[i*DW +: DW] = td[i];
    end
    for (int j = 0; j < NO; j++) m_tready[j] = mr[j];
  end

  axis_pkt_switch #(.BASE(0), .DATA_W(DW), .NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
    .clk(clk), .reset(reset), .clear(clear), .local_addr(local_addr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_rd_stb(rb_rd_stb), .rb_addr(rb_addr), .rb_data(rb_data)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t expq [NO][$];
  int checks = 0;
  int errors = 0;
  int cyc, lat, run, c1, c2, c3;
  logic [31:0] r;
`ifdef AXIS_PKT_SWITCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkdata(int tag, int in, int b, logic [15:0] dst);
    return {16'(tag), 16'(in), 16'(b), dst};
  endfunction

  task automatic exp_pkt(input int out, input int in, input logic [15:0] dst,
                         input int nb, input int tag, input int nkeep);
    beat_t e;
    for (int b = 0; b < nkeep; b++) begin
      e.d = mkdata(tag, in, b, dst);
      e.l = (b == nb - 1);
      expq[out].push_back(e);
    end
  endtask

  // Drives nsend of nb beats; a partial send leaves the next beat presented.
  task automatic send_pkt(input int in, input logic [15:0] dst, input int nb,
                          input int nsend, input int tag, output int cycles);
    logic hs, ok;
    cycles = 0;
    @(posedge clk); #1;
    for (int b = 0; b < nsend; b++) begin
      tv[in] = 1'b1;
      td[in] = mkdata(tag, in, b, dst);
      tl[in] = (b == nb - 1);
      ok = 1'b0;
      for (int w = 0; w < 200 && !ok; w++) begin
        @(negedge clk);
        hs = s_tready[in];
        @(posedge clk); #1;
        cycles++;
        if (hs) ok = 1'b1;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL in%0d handshake timeout: got no s_tready expected s_tready=1", in);
      end
    end
    if (nsend == nb) begin
      tv[in] = 1'b0;
      tl[in] = 1'b0;
    end else begin
      td[in] = mkdata(tag, in, nsend, dst);
      tl[in] = (nsend == nb - 1);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    rb_rd_stb = 1'b1; rb_addr = a;
    @(posedge clk); #1;
    rb_rd_stb = 1'b0;
    d = rb_data;
  endtask

  task automatic qcheck(input string tname);
    for (int j = 0; j < NO; j++)
      check($sformatf("%s out%0d leftover beats", tname, j), 64'(expq[j].size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; local_addr = 8'h01;
    set_stb = 1'b0; set_addr = '0; set_data = '0; rb_rd_stb = 1'b0; rb_addr = '0;
    for (int i = 0; i < NI; i++) begin tv[i] = 1'b0; tl[i] = 1'b0; td[i] = '0; end
    for (int j = 0; j < NO; j++) mr[j] = 1'b1;

    fork
      begin : monitor
        beat_t e;
        forever begin
          @(negedge clk);
          for (int j = 0; j < NO; j++) begin
            if (m_tvalid[j] && m_tready[j]) begin
              if (expq[j].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out%0d unexpected beat: got 0x%0h expected none", j,
                         m_tdata[j*DW +: DW]);
              end else begin
                e = expq[j].pop_front();
                check($sformatf("out%0d data", j), m_tdata[j*DW +: DW], e.d);
                check($sformatf("out%0d last", j), 64'(m_tlast[j]), 64'(e.l));
              end
            end
          end
        end
      end
    join_none

    #2;
    check("reset s_tready", 64'(s_tready), 64'd0);
    check("reset m_tvalid", 64'(m_tvalid), 64'd0);
    check("reset m_tlast", 64'(m_tlast), 64'd0);
    check("reset m_tdata", 64'(|m_tdata), 64'd0);
    check("reset rb_data", 64'(rb_data), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Local route 0x0105 -> output 2, latency and throughput
    wr(16'h0105, 32'h8000_0002);
    exp_pkt(2, 0, 16'h0105, 4, 1, 4);
    fork
      send_pkt(0, 16'h0105, 4, 4, 1, cyc);
      begin
        @(posedge clk); #1;
        lat = 0;
        for (int w = 0; w < 20; w++) begin
          @(posedge clk); lat++; #1;
          if (m_tvalid[2]) break;
        end
      end
    join
    check("header latency", 64'(lat), 64'd3);
    check("pkt1 cycles", 64'(cyc), 64'd7);

    // Remote route 0x07xx -> entry 0x007 -> output 3
    wr(16'h0007, 32'h8000_0003);
    exp_pkt(3, 1, 16'h0742, 3, 2, 3);
    send_pkt(1, 16'h0742, 3, 3, 2, cyc);
    check("pkt2 cycles", 64'(cyc), 64'd6);
    rd(10'h007, r);
    check("rb entry 0x007", 64'(r), 64'h8000_0003);
    rb_addr = 10'h105;
    repeat (2) @(posedge clk); #1;
    check("rb hold without strobe", 64'(rb_data), 64'h8000_0003);
    rd(10'h105, r);
    check("rb entry 0x105", 64'(r), 64'h8000_0002);
    wr(16'h0200, 32'h8000_0001);
    rd(10'h000, r);
    check("out-of-range write ignored", 64'(r), 64'd0);

    // Single-beat packet
    exp_pkt(2, 3, 16'h0105, 1, 3, 1);
    send_pkt(3, 16'h0105, 1, 1, 3, cyc);
    check("single-beat cycles", 64'(cyc), 64'd4);

    // Unrouted packet is consumed and dropped
    send_pkt(2, 16'h0199, 3, 3, 4, cyc);
    check("drop cycles", 64'(cyc), 64'd5);
    repeat (3) @(posedge clk);
    qcheck("basic");
    rd(10'd520, r);
    check("drop counter", 64'(r), STATS ? 64'd1 : 64'd0);
    rd(10'd514, r);
    check("in2 counter", 64'(r), STATS ? 64'd1 : 64'd0);
    rd(10'd518, r);
    check("out2 counter", 64'(r), STATS ? 64'd2 : 64'd0);
    rd(10'd521, r);
    check("unused counter addr", 64'(r), 64'd0);

    // Four inputs contend for output 1: order 0,1,2,3,0 with no bubbles
    wr(16'h0120, 32'h8000_0001);
    exp_pkt(1, 0, 16'h0120, 2, 10, 2);
    exp_pkt(1, 1, 16'h0120, 2, 11, 2);
    exp_pkt(1, 2, 16'h0120, 2, 12, 2);
    exp_pkt(1, 3, 16'h0120, 2, 13, 2);
    exp_pkt(1, 0, 16'h0120, 2, 14, 2);
    run = 0;
    fork
      begin
        send_pkt(0, 16'h0120, 2, 2, 10, cyc);
        send_pkt(0, 16'h0120, 2, 2, 14, cyc);
      end
      begin @(posedge clk); send_pkt(1, 16'h0120, 2, 2, 11, c1); end
      begin @(posedge clk); send_pkt(2, 16'h0120, 2, 2, 12, c2); end
      begin @(posedge clk); send_pkt(3, 16'h0120, 2, 2, 13, c3); end
      begin
        for (int w = 0; w < 40; w++) begin
          @(negedge clk);
          if (m_tvalid[1]) break;
        end
        while (m_tvalid[1] && run < 100) begin
          run++;
          @(negedge clk);
        end
      end
    join
    check("arb back-to-back beats", 64'(run), 64'd10);
    repeat (3) @(posedge clk);
    qcheck("arb");

    // Stall mid-packet, then clear
    exp_pkt(2, 0, 16'h0105, 4, 20, 2);
    send_pkt(0, 16'h0105, 4, 2, 20, cyc);
    mr[2] = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("stall m_tvalid", 64'(m_tvalid[2]), 64'd1);
    check("stall m_tdata", m_tdata[2*DW +: DW], mkdata(20, 0, 2, 16'h0105));
    check("stall s_tready", 64'(s_tready[0]), 64'd0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; tv[0] = 1'b0; tl[0] = 1'b0;
    check("clear m_tvalid", 64'(m_tvalid), 64'd0);
    check("clear s_tready", 64'(s_tready), 64'd0);
    mr[2] = 1'b1;
    rd(10'd520, r);
    check("counters after clear", 64'(r), 64'd0);
    rd(10'h105, r);
    check("table kept 0x105", 64'(r), 64'h8000_0002);
    rd(10'h120, r);
    check("table kept 0x120", 64'(r), 64'h8000_0001);
    qcheck("clear");

    // Asynchronous reset mid-packet
    exp_pkt(2, 1, 16'h0105, 4, 30, 2);
    send_pkt(1, 16'h0105, 4, 2, 30, cyc);
    reset = 1'b1;
    #1;
    check("async rst m_tvalid", 64'(m_tvalid), 64'd0);
    check("async rst m_tlast", 64'(m_tlast), 64'd0);
    check("async rst m_tdata", 64'(|m_tdata), 64'd0);
    check("async rst s_tready", 64'(s_tready), 64'd0);
    check("async rst rb_data", 64'(rb_data), 64'd0);
    tv[1] = 1'b0; tl[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(10'h105, r);
    check("table cleared 0x105", 64'(r), 64'd0);
    rd(10'h007, r);
    check("table cleared 0x007", 64'(r), 64'd0);
    send_pkt(2, 16'h0105, 2, 2, 31, cyc);
    check("post-reset drop cycles", 64'(cyc), 64'd4);
    repeat (3) @(posedge clk);
    qcheck("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_pkt_switch.md
Name: axis_pkt_switch

Overview:
- Parametrised NxM CVITA packet switch: NUM_INPUTS AXI-Stream slaves routed to NUM_OUTPUTS masters, packet-atomic.
- Routes on the 16-bit dst SID (tdata[15:0] of the header word) through a settings-bus-programmed route table with a valid bit per entry.
- Unrouted packets are dropped.
- Each output has its own round-robin arbiter.
- Sits between the NoC shell/radio ports and the host transport, replacing fixed square crossbars.

Parameters:
- BASE, 0, settings bus base address; the table occupies BASE..BASE+511.
- DATA_W, 64, tdata width per port (>=16).
- NUM_INPUTS, 4, slave port count (>=1).
- NUM_OUTPUTS, 4, master port count (>=1).
- OUT_W, $clog2(NUM_OUTPUTS) (min 1), width of a table port field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of FSMs and arbiters; table retained.
- local_addr  in  8  this device's address, compared with dst[15:8].
- s_tdata  in  NUM_INPUTS*DATA_W  flattened slave data; port i at [i*DATA_W +: DATA_W].
- s_tvalid/s_tlast  in  NUM_INPUTS  per-input valid/last.
- s_tready  out  NUM_INPUTS  per-input ready.
- m_tdata  out  NUM_OUTPUTS*DATA_W  flattened master data.
- m_tvalid/m_tlast  out  NUM_OUTPUTS  per-output valid/last.
- m_tready  in  NUM_OUTPUTS  per-output ready.
- set_stb  in  1  settings write strobe.
- set_addr  in  16  settings address.
- set_data  in  32  settings data.
- rb_rd_stb  in  1  readback strobe.
- rb_addr  in  10  readback address.
- rb_data  out  32  readback data.

Behaviour:
- Reset (async): s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, rb_data=0. All table entries invalid. Arbiter pointers at 0. Counters 0.
- Route table: 512 entries of {valid, port[OUT_W-1:0]}.
  - A write with set_stb and BASE<=set_addr<BASE+512 sets entry (set_addr-BASE) to {set_data[31], set_data[OUT_W-1:0]}.
  - A written port >= NUM_OUTPUTS stores valid=0.
- Index selection: if dst[15:8]==local_addr, index = {1'b1, dst[7:0]} (local half); else index = {1'b0, dst[15:8]} (remote half).
- Per-input FSM: IDLE -> LOOKUP -> REQ -> FWD, or IDLE -> LOOKUP -> DROP.
  - IDLE: s_tready=0. On s_tvalid, register dst and go to LOOKUP. The header is not consumed.
  - LOOKUP: 1-cycle registered table read. Valid entry -> REQ with the target port; invalid -> DROP.
  - REQ: request the target output and wait for grant.
  - FWD: combinational pass-through; m_tdata/tvalid/tlast = s_*, s_tready = m_tready. On the tlast handshake, release the output and go to IDLE.
  - DROP: s_tready=1; on the tlast handshake, go to IDLE.
- Minimum header latency: 3 cycles from s_tvalid to m_tvalid. After that, full throughput with no bubbles mid-packet.
- Per-output arbiter:
  - Idle output: grant the lowest-index requester at or above (last_grant+1) mod NUM_INPUTS. The grant registers in 1 cycle and is held until tlast is accepted.
  - A new grant may register in the same cycle tlast is accepted.
  - m_tvalid=0 when no grant is held.
- Simultaneous table write and lookup of the same entry: the lookup sees the old value. The write is effective from the next cycle.
- A single-beat packet (tvalid and tlast on the header) routes normally.
- clear: all FSMs -> IDLE, grants dropped, m_tvalid=0 the next cycle. Packets in flight are truncated; upstream must clear as well. Table untouched.
- Readback: when rb_rd_stb, rb_data updates the next cycle.
  - rb_addr[9]=0: rb_data = {valid, 0..., port} for table entry rb_addr[8:0].
  - rb_addr[9]=1: counters (see Optional Feature), otherwise 0.
  - rb_data holds its value between strobes.

Optional Feature:
- Macro: AXIS_PKT_SWITCH_STATS_EN.
- Defined: 32-bit wrapping packet counters, incremented on the tlast handshake.
  - Counter order: per input (rb_addr 512+i), per output (rb_addr 512+NUM_INPUTS+j), dropped packets (rb_addr 512+NUM_INPUTS+NUM_OUTPUTS).
  - Other counter addresses read 0.
  - Counters reset on reset or clear.
- Undefined: no counters are built; rb_addr[9]=1 reads 0.

Test Plan:
- Write entry 0x105={1,port 2} with local_addr=0x01. Send a 4-beat packet dst=0x0105 on input 0 -> packet appears intact on output 2, m_tvalid rises 3 cycles after s_tvalid, other outputs idle.
- Send dst=0x0742 on input 1, remote entry 0x007={1,port 3} -> routed to output 3. Read back rb_addr=0x007 -> 0x80000003.
- Send a packet to an invalid entry -> all beats consumed (s_tready=1), no output activity. With STATS_EN, the drop counter reads 1.
- Inputs 0–3 continuously send 2-beat packets to output 1 -> grant order 0,1,2,3,0. No bubble between packets when m_tready=1.
- Hold m_tready=0 mid-packet for 5 cycles, then assert clear -> m_tvalid=0 next cycle, all s_tready=0, table still reads its programmed values.
- Assert reset mid-packet -> all outputs drop to 0 immediately. After release, the table reads all-invalid and a new packet is dropped.
